// File: rtl/fifo_status.sv
// Circular FIFO with occupancy count, almost-full/almost-empty thresholds and sticky error flags.
// Latency: write visible (empty drops) after 1 clk; read data registered, valid 1 clk after rd edge.
// Backpressure: writes to a full FIFO are rejected unless a read is accepted in the same cycle; rejected ops set sticky flags.
//
// Ports:
//   clk          - core clock, all state on rising edge
//   reset        - asynchronous active-low reset
//   wr / w_data  - write request and data
//   rd           - read request
//   r_data       - registered read data, r_valid pulses for one cycle per accepted read
//   clr_err      - synchronous clear of overflow/underflow (a same-cycle error wins)
//   empty/full/almost_empty/almost_full/count - registered occupancy status
//   overflow/underflow - sticky rejected-write / rejected-read flags
module fifo_status #(
    parameter int adr_width = 4,
    parameter int dat_width = 8,
    parameter int af_lvl    = 2**adr_width - 2,
    parameter int ae_lvl    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [dat_width-1:0] w_data,
    input  logic                 rd,
    output logic [dat_width-1:0] r_data,
    output logic                 r_valid,
    input  logic                 clr_err,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic [adr_width:0]   count,
    output logic                 overflow,
    underflow
);

    localparam int                 DEPTH   = 2**adr_width;
    localparam logic [adr_width:0] DEPTH_C = (adr_width+1)'(DEPTH);
    localparam logic [adr_width:0] AF_C    = (adr_width+1)'(af_lvl);
    localparam logic [adr_width:0] AE_C    = (adr_width+1)'(ae_lvl);

    logic [dat_width-1:0] r_mem [DEPTH];
    logic [adr_width-1:0] r_wptr;
    logic [adr_width-1:0] r_rptr;

    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic [adr_width:0]   w_count_next;

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    // An empty FIFO never forwards write data straight to a read.
    assign w_wr_ok = wr & (~full | rd);
    assign w_rd_ok = rd & ~empty;

    always_comb begin
        w_count_next = count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_next = count + 1'b1;
            2'b01:   w_count_next = count - 1'b1;
            default: w_count_next = count;
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            // When full with both accepted, w_ptr == r_ptr: the read sees the
            // old (oldest) word because the array update is non-blocking.
            if (w_rd_ok) begin
                r_data <= r_mem[r_rptr];
                r_rptr <= r_rptr + 1'b1;
            end
            r_valid <= w_rd_ok;

            count        <= w_count_next;
            empty        <= (w_count_next == '0);
            full         <= (w_count_next == DEPTH_C);
            almost_empty <= (w_count_next <= AE_C);
            almost_full  <= (w_count_next >= AF_C);

            // New error in the same cycle as clr_err keeps the flag set.
            overflow  <= (overflow  & ~clr_err) | (wr & ~w_wr_ok);
            underflow <= (underflow & ~clr_err) | (rd & ~w_rd_ok);
        end
    end

endmodule

// File: tb/tb_fifo_status.sv
module tb_fifo_status;

    localparam int ADR   = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 1;

    logic          clk;
    logic          reset;
    logic          wr;
    logic [DW-1:0] w_data;
    logic          rd;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          clr_err;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [ADR:0]  count;
    logic          overflow;
    logic          underflow;

    fifo_status #(
        .adr_width (ADR),
        .dat_width (DW),
        .af_lvl    (AF),
        .ae_lvl    (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .clr_err      (clr_err),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    function automatic void chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endfunction

    // Behavioural model: a queue of stored words plus the last popped word.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rdata = '0;
    bit            m_rvalid = 1'b0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    bit            m_wok;
    bit            m_rok;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_rdata  = '0;
            m_rvalid = 1'b0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else begin
            m_wok = wr && ((q.size() != DEPTH) || rd);
            m_rok = rd && (q.size() != 0);
            if (m_rok) m_rdata = q.pop_front();
            m_rvalid = m_rok;
            if (m_wok) q.push_back(w_data);
            m_ovf = (m_ovf && !clr_err) || (wr && !m_wok);
            m_unf = (m_unf && !clr_err) || (rd && !m_rok);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("count",        int'(count),        q.size());
            chk("empty",        int'(empty),        int'(q.size() == 0));
            chk("full",         int'(full),         int'(q.size() == DEPTH));
            chk("almost_empty", int'(almost_empty), int'(q.size() <= AE));
            chk("almost_full",  int'(almost_full),  int'(q.size() >= AF));
            chk("r_valid",      int'(r_valid),      int'(m_rvalid));
            chk("r_data",       int'(r_data),       int'(m_rdata));
            chk("overflow",     int'(overflow),     int'(m_ovf));
            chk("underflow",    int'(underflow),    int'(m_unf));
        end
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        wr      = w;
        w_data  = d;
        rd      = r;
        clr_err = c;
        @(posedge clk);
        #1;
        wr      = 1'b0;
        rd      = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"},     int'(count),        0);
        chk({tag, "_empty"},     int'(empty),        1);
        chk({tag, "_aempty"},    int'(almost_empty), 1);
        chk({tag, "_full"},      int'(full),         0);
        chk({tag, "_afull"},     int'(almost_full),  0);
        chk({tag, "_rvalid"},    int'(r_valid),      0);
        chk({tag, "_rdata"},     int'(r_data),       0);
        chk({tag, "_overflow"},  int'(overflow),     0);
        chk({tag, "_underflow"}, int'(underflow),    0);
    endtask

    int pw;
    int pr;
    int seed_data;

    initial begin
        reset   = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        clr_err = 1'b0;
        w_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset  = 1'b1;
        chk_on = 1'b1;

        // Fill with 0x00..0x0F.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, DW'(i), 1'b0, 1'b0);
            chk("fill_count", int'(count), i + 1);
            chk("fill_afull", int'(almost_full), int'(i + 1 >= 14));
            chk("fill_full",  int'(full), int'(i + 1 == 16));
        end
        chk("fill_ovf", int'(overflow), 0);

        // Extra write to full FIFO, then clear.
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("extra_ovf",   int'(overflow), 1);
        chk("extra_count", int'(count), 16);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", int'(overflow), 0);

        // Drain: data must be 0x00..0x0F, untouched by the rejected 0xAA.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_data",   int'(r_data), i);
            chk("drain_valid",  int'(r_valid), 1);
            chk("drain_aempty", int'(almost_empty), int'(15 - i <= 1));
        end
        chk("drain_empty", int'(empty), 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("under_flag",  int'(underflow), 1);
        chk("under_valid", int'(r_valid), 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Concurrent wr/rd at count 5 across pointer wrap.
        pw = 0;
        pr = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, DW'(8'h40 + pw), 1'b0, 1'b0);
            pw++;
        end
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, DW'(8'h40 + pw), 1'b1, 1'b0);
            pw++;
            chk("conc_count", int'(count), 5);
            chk("conc_data",  int'(r_data), int'(DW'(8'h40 + pr)));
            pr++;
        end

        // Concurrent at full.
        for (int i = 0; i < 11; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hC3, 1'b1, 1'b0);
        chk("full_rw_full",  int'(full), 1);
        chk("full_rw_count", int'(count), 16);
        chk("full_rw_ovf",   int'(overflow), 0);

        // Concurrent at empty.
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h3C, 1'b1, 1'b0);
        chk("empty_rw_count", int'(count), 1);
        chk("empty_rw_unf",   int'(underflow), 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("empty_rw_data",  int'(r_data), 8'h3C);

        // Asynchronous reset mid-stream at count 9.
        for (int i = 0; i < 9; i++) cyc(1'b1, DW'(8'h90 + i), 1'b0, 1'b0);
        chk("pre_rst_count", int'(count), 9);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_rst");
        #1;
        reset = 1'b1;
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        chk("post_rst_count", int'(count), 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_data",  int'(r_data), 8'h55);
        chk("post_rst_valid", int'(r_valid), 1);

        // Randomized phases with varying write/read bias.
        seed_data = 0;
        for (int ph = 0; ph < 20; ph++) begin
            int wp;
            int rp;
            wp = (ph % 4 == 0) ? 85 : (ph % 4 == 1) ? 15 : 50;
            rp = (ph % 4 == 0) ? 15 : (ph % 4 == 1) ? 85 : 50;
            for (int i = 0; i < 500; i++) begin
                cyc(logic'($urandom_range(99) < wp), DW'($urandom),
                    logic'($urandom_range(99) < rp), logic'($urandom_range(15) == 0));
                seed_data++;
            end
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_status.md
# fifo_status

Parametrised synchronous circular FIFO with occupancy count, programmable almost-full/almost-empty thresholds, registered read data and sticky overflow/underflow error flags. It is the standard buffering block between producer and consumer sub-blocks in each project module, for example a PS/2 or UART receiver feeding game logic, or game logic feeding a VGA or sound engine. It has a single clock domain.

## Interface
- adr_width, 4, pointer width; depth DEPTH = 2**adr_width entries
- dat_width, 8, data word width
- af_lvl, 2**adr_width-2, almost_full asserted when count >= af_lvl (legal range 1..DEPTH)
- ae_lvl, 1, almost_empty asserted when count <= ae_lvl (legal range 0..DEPTH-1)

- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- wr  input  1  write request
- w_data  input  dat_width  write data, sampled on an accepted write
- rd  input  1  read request
- r_data  output  dat_width  registered read data
- r_valid  output  1  one-cycle pulse; r_data holds a word popped on the previous edge
- clr_err  input  1  synchronous clear of overflow/underflow
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- almost_empty  output  1  count <= ae_lvl
- almost_full  output  1  count >= af_lvl
- count  output  adr_width+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky flag: a write was rejected
- underflow  output  1  sticky flag: a read was rejected

## Operation
- Storage: DEPTH x dat_width array, with write pointer w_ptr and read pointer r_ptr (adr_width bits each). Both pointers wrap naturally from DEPTH-1 to 0.
- Accept rules, evaluated on the state before the edge:
  - wr_ok = wr & (~full | rd). A write to a full FIFO is accepted only if a read occurs in the same cycle.
  - rd_ok = rd & ~empty. A read from an empty FIFO is always rejected. There is no write-through.
- Accepted write: mem[w_ptr] <= w_data, then w_ptr += 1.
- Accepted read: r_data <= mem[r_ptr], then r_ptr += 1, and r_valid <= 1. Otherwise r_valid <= 0 and r_data holds its value.
- count next state:
  - +1 on wr_ok & ~rd_ok
  - -1 on rd_ok & ~wr_ok
  - unchanged otherwise, including when both are accepted
- empty, full, almost_empty and almost_full are registered and derived from count_next, so they always agree with count in the same cycle.
- Error flags:
  - overflow <= 1 on wr & ~wr_ok.
  - underflow <= 1 on rd & ~rd_ok.
  - clr_err clears both flags. If clr_err and a new error occur in the same cycle, the error wins and the flag stays 1.
- Simultaneous wr and rd:
  - Empty: the write is accepted, the read is rejected and underflow is set. Count becomes 1.
  - Full: both are accepted; count stays DEPTH and full stays 1.
  - Otherwise: both are accepted and count is unchanged.

## Timing
- Reset values (reset low, asynchronous):
  - w_ptr = r_ptr = 0, count = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - r_valid = 0, r_data = 0, overflow = 0, underflow = 0
- Array contents are not reset.
- Reset asserted mid-operation discards all contents immediately. The first write after reset is accepted on the first rising edge where reset is high.
- Write-to-empty-deassert latency: 1 clock. Write-to-readable: the word can be popped on the next edge.
- Read latency: the rd edge loads r_data; r_data and r_valid are valid from that edge until the next edge.
- All status outputs change only on rising clk edges (except under reset) and carry no combinational path from wr or rd.

## Test plan
- Reset, then 16 writes of 0x00..0x0F (adr_width=4) -> count walks 0..16; almost_full rises when count reaches 14 and full at 16; overflow stays 0.
- Full FIFO, one extra write of 0xAA -> overflow=1, count=16, data unchanged; clr_err pulse -> overflow=0.
- 16 reads from full -> r_data sequence 0x00..0x0F with r_valid high each cycle; empty=1 after the last; almost_empty rises at count 1; a 17th read sets underflow=1 with r_valid=0.
- Simultaneous wr/rd at count 5 for 40 cycles (pointer wrap) -> count stays 5 and output order matches write order; at full -> both accepted, full stays 1; at empty -> count becomes 1, underflow=1.
- reset pulled low mid-stream at count 9 -> asynchronous clear to the reset values above; next write 0x55 then read returns 0x55.
- Random wr/rd/clr_err for 10k cycles against a queue model -> r_data, count, all flags and sticky errors match every cycle.
